// File: rtl/vga_timing_if.sv
// Raster timing bus: pixel strobe, coordinates, syncs and blanking
// produced by vga_timing and consumed by the downstream region decoders.
interface vga_timing_if;
  logic       pixel_tick;
  logic [9:0] x;
  logic [9:0] y;
  logic       hsync;
  logic       vsync;
  logic       video_on;
  logic       frame_start;

  modport master (
    output pixel_tick, x, y, hsync, vsync, video_on, frame_start
  );

  modport slave (
    input pixel_tick, x, y, hsync, vsync, video_on, frame_start
  );
endinterface

// File: rtl/vga_timing.sv
// 640x480@60 raster timing generator: divides clk by 4 into a pixel strobe
// and runs the x/y counters with registered sync/blank/frame decodes.
module vga_timing #(
  parameter int unsigned H_VISIBLE = 640,
  parameter int unsigned H_FP      = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BP      = 48,
  parameter int unsigned V_VISIBLE = 480,
  parameter int unsigned V_FP      = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BP      = 33
) (
  input  logic         clk,
  input  logic         reset_n,
  vga_timing_if.master vga
);

  localparam int unsigned H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_MAX    = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_MAX    = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
  localparam logic [9:0] HS_FIRST = 10'(H_VISIBLE + H_FP);
  localparam logic [9:0] HS_LAST  = 10'(H_VISIBLE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_VISIBLE + V_FP);
  localparam logic [9:0] VS_LAST  = 10'(V_VISIBLE + V_FP + V_SYNC - 1);

  logic [1:0] div_q, div_d;
  logic [9:0] x_q, x_d;
  logic [9:0] y_q, y_d;
  logic       hsync_q, hsync_d;
  logic       vsync_q, vsync_d;
  logic       video_on_q, video_on_d;
  logic       frame_start_q, frame_start_d;
  logic       pixel_tick;
  logic       x_wrap;

  assign pixel_tick = (div_q == 2'd3);
  assign x_wrap     = pixel_tick && (x_q == H_MAX);

  always_comb begin
    div_d = div_q + 2'd1;
    x_d   = x_q;
    y_d   = y_q;
    if (pixel_tick) begin
      if (x_q == H_MAX) begin
        x_d = '0;
        y_d = (y_q == V_MAX) ? '0 : y_q + 10'd1;
      end else begin
        x_d = x_q + 10'd1;
      end
    end
  end

  // Decodes look at the next-state counts so the registered outputs line up
  // with the x/y values presented on the same clock.
  always_comb begin
    hsync_d       = !((x_d >= HS_FIRST) && (x_d <= HS_LAST));
    vsync_d       = !((y_d >= VS_FIRST) && (y_d <= VS_LAST));
    video_on_d    = (x_d < H_VIS) && (y_d < V_VIS);
    frame_start_d = x_wrap && (y_q == V_MAX);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_q         <= '0;
      x_q           <= '0;
      y_q           <= '0;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      video_on_q    <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      div_q         <= div_d;
      x_q           <= x_d;
      y_q           <= y_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      video_on_q    <= video_on_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign vga.pixel_tick  = pixel_tick;
  assign vga.x           = x_q;
  assign vga.y           = y_q;
  assign vga.hsync       = hsync_q;
  assign vga.vsync       = vsync_q;
  assign vga.video_on    = video_on_q;
  assign vga.frame_start = frame_start_q;

endmodule
